// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath width, fetch FSM states and fetch buffer entry.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. Storage is cleared on reset so the head reads 0.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, PC halt control, redirect flush.
// Optional misaligned-fetch trap enabled with `define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] curr_pc,
  output logic            pc_halt,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            has_space;
  logic            misalign;
  logic            req_fire;
  logic            rsp_push;
  logic            fault_push;
  logic            push;
  logic            pop;
  logic            unused_fault;

  assign has_space = count < CW'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign   = curr_pc[1:0] != 2'b00;
  assign fault_push = reset_n && (state == IDLE) && has_space && misalign && !redirect;
`else
  assign misalign   = 1'b0;
  assign fault_push = 1'b0;
`endif

  // Outputs are forced to their idle values while reset is held.
  assign imem_req_valid = reset_n && (state == IDLE) && !redirect && has_space && !misalign;
  assign imem_req_addr  = curr_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_halt        = !(reset_n && (req_fire || redirect));

  assign rsp_push = (state == WAIT) && imem_rsp_valid && !redirect;
  assign push     = rsp_push || fault_push;
  assign pop      = fetch_valid && fetch_ready;

  always_comb begin
    push_entry = '{pc: out_pc, instr: imem_rsp_data, fault: 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    if (fault_push) begin
      push_entry = '{pc: curr_pc, instr: '0, fault: 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      out_pc <= '0;
    end else begin
      state <= next_state;
      if (req_fire) begin
        out_pc <= curr_pc;
      end
    end
  end

  // A redirect while waiting either lands with its response (back to IDLE)
  // or leaves the stale response still in flight, which DROP swallows.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_fire) next_state = WAIT;
      WAIT: begin
        if (redirect)            next_state = imem_rsp_valid ? IDLE : DROP;
        else if (imem_rsp_valid) next_state = IDLE;
      end
      DROP: if (imem_rsp_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign fetch_valid = count != '0;
  assign fetch_instr = head.instr;
  assign fetch_pc    = head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault  = fetch_valid && head.fault;
  assign unused_fault = 1'b0;
`else
  assign fetch_fault  = 1'b0;
  assign unused_fault = head.fault;
`endif

  rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!reset_n) imem_rsp_valid |-> (state != IDLE)
  );

endmodule
